button_gesture: RTL and testbench

Classifies the debounced button stream into single-cycle gesture pulses: short press, double press, long press, and optional auto-repeat while held. It sits directly downstream of the debounce stage. It consumes that stage's debounced level and its one-tick down/up pulses, and drives the zoom/pan control logic of the Mandelbrot viewer.

---
 rtl/button_pkg.sv | 23 ++
 rtl/button_gesture.sv | 137 +++++++++++++
 tb/tb_button_gesture.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and 100 MHz default timing constants for the button gesture classifier.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } gesture_state_t;

  localparam int unsigned LONG_CNT_DEF = 50_000_000;  // 0.5 s
  localparam int unsigned DBL_CNT_DEF  = 25_000_000;  // 0.25 s
  localparam int unsigned RPT_CNT_DEF  = 10_000_000;  // 0.1 s

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_gesture.sv
// Turns debounced press/release pulses into short, double, long and repeat gesture pulses.
// Define BUTTON_GESTURE_REPEAT_EN to enable auto-repeat while a long press is held.
module button_gesture
  import button_pkg::*;
#(
  parameter int unsigned LONG_CNT = LONG_CNT_DEF,
  parameter int unsigned DBL_CNT  = DBL_CNT_DEF,
  parameter int unsigned RPT_CNT  = RPT_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic btn_dn,
  input  logic btn_up,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press,
  output logic held
);

`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  // The repeat interval only sizes the counter when repeat is built in.
  localparam int unsigned CNT_MAX = max3(LONG_CNT, DBL_CNT, REPEAT_EN ? RPT_CNT : 0);
  localparam int          CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CNT - 1);
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CNT - 1);
`endif

  gesture_state_t state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic           cnt_en, cnt_clr;
  logic           short_next, double_next, long_next, repeat_next;

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;

    unique case (state)
      IDLE: begin
        if (btn_dn && !btn_up) state_next = PRESS1;
      end
      PRESS1: begin
        cnt_en = 1'b1;
        if (btn_up) begin
          state_next = WAIT2;
        end else if (cnt == LONG_LAST) begin
          state_next = LONG;
          long_next  = 1'b1;
        end
      end
      WAIT2: begin
        cnt_en = 1'b1;
        // A release never starts a second press, so btn_up masks a coincident btn_dn.
        if (btn_dn && !btn_up) begin
          state_next  = PRESS2;
          double_next = 1'b1;
        end else if (cnt == DBL_LAST) begin
          state_next = IDLE;
          short_next = 1'b1;
        end
      end
      PRESS2: begin
        if (btn_up) state_next = IDLE;
      end
      LONG: begin
        if (btn_up) begin
          state_next = IDLE;
        end
`ifdef BUTTON_GESTURE_REPEAT_EN
        else begin
          cnt_en = 1'b1;
          if (cnt == RPT_LAST) begin
            repeat_next = 1'b1;
            cnt_clr     = 1'b1;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase

    // Every state change restarts the count; all counting states leave or clear
    // before reaching their limit, so the counter cannot wrap.
    if (state_next != state || cnt_clr) cnt_next = '0;
    else if (cnt_en)                    cnt_next = cnt + CW'(1);
    else                                cnt_next = cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      short_press  <= short_next;
      double_press <= double_next;
      long_press   <= long_next;
      held         <= btn;
    end
  end

`ifdef BUTTON_GESTURE_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) repeat_press <= 1'b0;
    else     repeat_press <= repeat_next;
  end
`else
  assign repeat_press = 1'b0;

  logic unused_repeat;
  assign unused_repeat = repeat_next;
`endif

endmodule

// File: tb/tb_button_gesture.sv
// Self-checking bench for button_gesture: directed gesture scenarios plus a randomized
// run, all compared cycle by cycle against a deadline-based reference model.
module tb_button_gesture;

  localparam int L = 20;
  localparam int D = 10;
  localparam int R = 5;
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk, rst, btn, btn_dn, btn_up;
  logic short_press, double_press, long_press, repeat_press, held;

  button_gesture #(.LONG_CNT(L), .DBL_CNT(D), .RPT_CNT(R)) dut (
    .clk(clk), .rst(rst), .btn(btn), .btn_dn(btn_dn), .btn_up(btn_up),
    .short_press(short_press), .double_press(double_press), .long_press(long_press),
    .repeat_press(repeat_press), .held(held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Reference model: which phase of a gesture we are in, plus the absolute cycle at
  // which that phase's timeout fires.
  typedef enum {M_IDLE, M_DOWN, M_GAP, M_DOWN2, M_HOLD} mphase_t;
  mphase_t m_phase;
  int      m_deadline;
  logic    e_short, e_double, e_long, e_rep, e_held;

  // Pulse log for the current scenario; times are the cycle at which the pulse is seen.
  int n_short, n_double, n_long, n_rep;
  int t_short, t_double, t_long;
  int rep_times[$];

  function automatic void model_reset();
    m_phase = M_IDLE;
    m_deadline = 0;
    {e_short, e_double, e_long, e_rep, e_held} = '0;
  endfunction

  function automatic void model_step(input logic dn, input logic up, input logic b, input int c);
    {e_short, e_double, e_long, e_rep} = '0;
    e_held = b;
    case (m_phase)
      M_IDLE:  if (dn && !up) begin m_phase = M_DOWN; m_deadline = c + L; end
      M_DOWN:  if (up) begin m_phase = M_GAP; m_deadline = c + D; end
               else if (c == m_deadline) begin
                 e_long = 1'b1; m_phase = M_HOLD; m_deadline = c + R;
               end
      M_GAP:   if (dn && !up) begin e_double = 1'b1; m_phase = M_DOWN2; end
               else if (c == m_deadline) begin e_short = 1'b1; m_phase = M_IDLE; end
      M_DOWN2: if (up) m_phase = M_IDLE;
      M_HOLD:  if (up) m_phase = M_IDLE;
               else if (REP && c == m_deadline) begin e_rep = 1'b1; m_deadline = c + R; end
      default: m_phase = M_IDLE;
    endcase
  endfunction

  function automatic void clear_log();
    n_short = 0; n_double = 0; n_long = 0; n_rep = 0;
    t_short = -1; t_double = -1; t_long = -1;
    rep_times.delete();
  endfunction

  // One clock cycle: drive inputs, step the model, compare every output against it.
  task automatic tick(input logic dn, input logic up);
    logic [4:0] got, exp;
    @(negedge clk);
    btn_dn = dn;
    btn_up = up;
    if (up) btn = 1'b0;
    else if (dn) btn = 1'b1;
    @(posedge clk);
    model_step(dn, up, btn, cyc);
    #1;
    got = {short_press, double_press, long_press, repeat_press, held};
    exp = {e_short, e_double, e_long, e_rep, e_held};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_outputs c=%0d {short,dbl,long,rpt,held} got=%b exp=%b", cyc + 1, got, exp);
    end
    checks++;
    if ($countones({short_press, double_press, long_press, repeat_press}) > 1) begin
      errors++;
      $display("FAIL pulse_exclusive c=%0d got=%b exp=at most one pulse", cyc + 1, got[4:1]);
    end
    if (short_press)  begin n_short++;  if (t_short  < 0) t_short  = cyc + 1; end
    if (double_press) begin n_double++; if (t_double < 0) t_double = cyc + 1; end
    if (long_press)   begin n_long++;   if (t_long   < 0) t_long   = cyc + 1; end
    if (repeat_press) begin n_rep++;    rep_times.push_back(cyc + 1); end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = 1'b0; btn_dn = 1'b0; btn_up = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({short_press, double_press, long_press, repeat_press, held} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {short_press, double_press, long_press, repeat_press, held});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_log();
    cyc = 0;
  endtask

  task automatic run_seq(input int dn0, input int up0, input int dn1, input int up1, input int n);
    do_reset();
    for (int c = 0; c < n; c++)
      tick(c == dn0 || c == dn1, c == up0 || c == up1);
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick(1'b0, 1'b1);   // a stray release in idle is ignored
    tick(1'b0, 1'b0);
    expect_int("reset_no_pulse", n_short + n_double + n_long + n_rep, 0);
  endtask

  task automatic test_short();
    run_seq(0, 5, -1, -1, 30);
    expect_int("short_time", t_short, 16);
    expect_int("short_count", n_short, 1);
    expect_int("short_others", n_double + n_long + n_rep, 0);
  endtask

  task automatic test_double();
    run_seq(0, 5, 9, 30, 50);
    expect_int("double_time", t_double, 10);
    expect_int("double_count", n_double, 1);
    expect_int("double_others", n_short + n_long + n_rep, 0);
  endtask

  task automatic test_long_repeat();
    int exp_t[$];
    run_seq(0, 40, -1, -1, 55);
    expect_int("long_time", t_long, 21);
    expect_int("long_count", n_long, 1);
    if (REP) exp_t = '{26, 31, 36};
    expect_int("repeat_count", n_rep, exp_t.size());
    for (int i = 0; i < exp_t.size() && i < rep_times.size(); i++)
      expect_int($sformatf("repeat_time_%0d", i), rep_times[i], exp_t[i]);
    expect_int("long_others", n_short + n_double, 0);
  endtask

  task automatic test_boundaries();
    run_seq(0, 20, -1, -1, 40);
    expect_int("bnd_up_at_long_no_long", n_long, 0);
    expect_int("bnd_up_at_long_short_time", t_short, 31);
    run_seq(0, 5, 15, 20, 40);
    expect_int("bnd_dn_at_timeout_double", t_double, 16);
    expect_int("bnd_dn_at_timeout_no_short", n_short, 0);
  endtask

  task automatic test_reset_mid_gesture();
    do_reset();
    tick(1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0);
    // In WAIT2 now: raise the level so held is visibly 1 before reset.
    @(negedge clk);
    btn = 1'b1;
    @(posedge clk);
    #1;
    expect_int("mid_held_before_rst", int'(held), 1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({short_press, double_press, long_press, repeat_press, held} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_immediate got=%b exp=00000",
               {short_press, double_press, long_press, repeat_press, held});
    end
    repeat (2) @(negedge clk);
    btn = 1'b0;
    rst = 1'b0;
    model_reset();
    clear_log();
    cyc = 0;
    repeat (30) tick(1'b0, 1'b0);
    expect_int("mid_no_pulse_after_release", n_short + n_double + n_long + n_rep, 0);
  endtask

  task automatic test_long_hold();
    run_seq(0, 100, -1, -1, 110);
    expect_int("hold100_long", n_long, 1);
    expect_int("hold100_repeats", n_rep, REP ? 15 : 0);
  endtask

  task automatic test_random();
    bit long_mode;
    logic dn, up;
    int r;
    do_reset();
    long_mode = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      dn = 1'b0;
      up = 1'b0;
      if (!btn) begin
        if (r < 8) begin
          dn = 1'b1;
          long_mode = ($urandom_range(0, 3) == 0);
        end else if (r == 99) begin
          up = 1'b1;
        end
      end else begin
        up = long_mode ? (r < 2) : (r < 7);
      end
      tick(dn, up);
    end
    checks++;
    if (n_short == 0 || n_double == 0 || n_long == 0) begin
      errors++;
      $display("FAIL random_coverage got short=%0d dbl=%0d long=%0d exp=all nonzero",
               n_short, n_double, n_long);
    end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; btn_dn = 1'b0; btn_up = 1'b0;
    cyc = 0;
    model_reset();
    clear_log();
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_boundaries();
    test_reset_mid_gesture();
    test_long_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
